// File: rtl/life_gen_scheduler.sv
// 8x8 toroidal Game-of-Life (B3/S23) grid register with load/run/pause/step sequencing
// and automatic halt on extinction, still life or generation-counter saturation.
module life_gen_scheduler #(
   parameter int TICK_DIV = 12_500_000,
   parameter int TICK_W   = 24,
   parameter int GEN_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [63:0]      seed,
   input  logic             start,
   input  logic             pause,
   input  logic             step,
   output logic [63:0]      grid,
   output logic [GEN_W-1:0] gen_count,
   output logic             gen_pulse,
   output logic             running,
   output logic             halted,
   output logic [1:0]       halt_reason
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PAUSE = 2'd1,
      RUN   = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [63:0]       grid_q, grid_d;
   logic [GEN_W-1:0]  gen_q, gen_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [1:0]        reason_q, reason_d;
   logic              pulse_q, pulse_d;

   logic [63:0]       next_grid;
   logic [GEN_W-1:0]  gen_inc;
   logic              tick_terminal;
   logic              apply;

   assign gen_inc       = gen_q + GEN_W'(1);
   assign tick_terminal = (tick_q == TICK_W'(TICK_DIV - 1));

   // Each cell sums its eight wrap-around neighbours; rows and columns wrap modulo 8.
   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_cell
         localparam int R  = gi / 8;
         localparam int C  = gi % 8;
         localparam int RU = (R + 7) % 8;
         localparam int RD = (R + 1) % 8;
         localparam int CL = (C + 7) % 8;
         localparam int CR = (C + 1) % 8;
         logic [3:0] n_cnt;
         assign n_cnt = {3'b000, grid_q[RU*8+CL]} + {3'b000, grid_q[RU*8+C]}
                      + {3'b000, grid_q[RU*8+CR]} + {3'b000, grid_q[R*8+CL]}
                      + {3'b000, grid_q[R*8+CR]}  + {3'b000, grid_q[RD*8+CL]}
                      + {3'b000, grid_q[RD*8+C]}  + {3'b000, grid_q[RD*8+CR]};
         assign next_grid[gi] = (n_cnt == 4'd3) | (grid_q[gi] & (n_cnt == 4'd2));
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      grid_d   = grid_q;
      gen_d    = gen_q;
      tick_d   = tick_q;
      reason_d = reason_q;
      pulse_d  = 1'b0;
      apply    = 1'b0;

      if (load) begin
         grid_d   = seed;
         gen_d    = '0;
         tick_d   = '0;
         reason_d = 2'b00;
         state_d  = PAUSE;
      end else begin
         case (state_q)
            PAUSE: begin
               if (pause) begin
                  state_d = PAUSE;
               end else if (start) begin
                  state_d = RUN;
               end else if (step) begin
                  apply = 1'b1;
               end
            end
            RUN: begin
               // A pause on the terminal edge still lets that generation land.
               if (tick_terminal) begin
                  tick_d = '0;
                  apply  = 1'b1;
               end else if (!pause) begin
                  tick_d = tick_q + TICK_W'(1);
               end
               if (pause) begin
                  state_d = PAUSE;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase

         if (apply) begin
            grid_d  = next_grid;
            gen_d   = gen_inc;
            pulse_d = 1'b1;
            if (next_grid == 64'd0) begin
               state_d  = HALT;
               reason_d = 2'b01;
            end else if (next_grid == grid_q) begin
               state_d  = HALT;
               reason_d = 2'b10;
            end else if (gen_inc == {GEN_W{1'b1}}) begin
               state_d  = HALT;
               reason_d = 2'b11;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         grid_q   <= '0;
         gen_q    <= '0;
         tick_q   <= '0;
         reason_q <= 2'b00;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         grid_q   <= grid_d;
         gen_q    <= gen_d;
         tick_q   <= tick_d;
         reason_q <= reason_d;
         pulse_q  <= pulse_d;
      end
   end

   assign grid        = grid_q;
   assign gen_count   = gen_q;
   assign gen_pulse   = pulse_q;
   assign running     = (state_q == RUN);
   assign halted      = (state_q == HALT);
   assign halt_reason = reason_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed bench for life_gen_scheduler: patterns, run timing, priorities, saturation, reset.
module tb_life_gen_scheduler;

   logic        clk = 1'b0;
   logic        reset, load, start, pause, step;
   logic [63:0] seed;
   logic [63:0] grid;
   logic [15:0] gen_count;
   logic        gen_pulse, running, halted;
   logic [1:0]  halt_reason;

   logic        s_reset, s_load, s_start, s_pause, s_step;
   logic [63:0] s_seed;
   logic [63:0] s_grid;
   logic [2:0]  s_gen_count;
   logic        s_gen_pulse, s_running, s_halted;
   logic [1:0]  s_halt_reason;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   life_gen_scheduler #(.TICK_DIV(4), .TICK_W(4), .GEN_W(16)) u_dut (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .start(start),
      .pause(pause), .step(step), .grid(grid), .gen_count(gen_count),
      .gen_pulse(gen_pulse), .running(running), .halted(halted),
      .halt_reason(halt_reason)
   );

   life_gen_scheduler #(.TICK_DIV(4), .TICK_W(4), .GEN_W(3)) u_sat (
      .clk(clk), .reset(s_reset), .load(s_load), .seed(s_seed), .start(s_start),
      .pause(s_pause), .step(s_step), .grid(s_grid), .gen_count(s_gen_count),
      .gen_pulse(s_gen_pulse), .running(s_running), .halted(s_halted),
      .halt_reason(s_halt_reason)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_load(input logic [63:0] v);
      seed = v; load = 1'b1; cyc(1); load = 1'b0;
   endtask

   task automatic do_step();
      step = 1'b1; cyc(1); step = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   task automatic do_pause();
      pause = 1'b1; cyc(1); pause = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; cyc(2); reset = 1'b0;
      vectors++;
      if ({grid, gen_count, gen_pulse, running, halted, halt_reason} !== 84'd0) begin
         miscompares++;
         $display("FAIL reset_outputs grid=%h gen=%0d pulse=%b run=%b halt=%b reason=%b exp all zero",
                  grid, gen_count, gen_pulse, running, halted, halt_reason);
      end
      do_start(); do_step(); cyc(5);
      vectors++;
      if (running !== 1'b0 || grid !== 64'd0 || gen_count !== 16'd0) begin
         miscompares++;
         $display("FAIL idle_ignores run=%b grid=%h gen=%0d exp 0/0/0", running, grid, gen_count);
      end
      $display("test_reset done");
   endtask

   task automatic test_blinker();
      do_load(64'h0E00);
      vectors++;
      if (grid !== 64'h0E00 || gen_count !== 16'd0 || running !== 1'b0 || halted !== 1'b0) begin
         miscompares++;
         $display("FAIL blink_load grid=%h gen=%0d run=%b halt=%b exp 0e00/0/0/0",
                  grid, gen_count, running, halted);
      end
      do_step();
      vectors++;
      if (grid !== 64'h0000_0000_0004_0404 || gen_count !== 16'd1 || gen_pulse !== 1'b1) begin
         miscompares++;
         $display("FAIL blink_step1 grid=%h gen=%0d pulse=%b exp 40404/1/1", grid, gen_count, gen_pulse);
      end
      cyc(1);
      vectors++;
      if (gen_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL blink_pulse_width pulse=%b exp 0", gen_pulse);
      end
      do_step();
      vectors++;
      if (grid !== 64'h0E00 || gen_count !== 16'd2 || running !== 1'b0 || halted !== 1'b0) begin
         miscompares++;
         $display("FAIL blink_step2 grid=%h gen=%0d run=%b halt=%b exp 0e00/2/0/0",
                  grid, gen_count, running, halted);
      end
      $display("test_blinker done");
   endtask

   task automatic test_still_life();
      do_load(64'h0303);
      do_step();
      vectors++;
      if (grid !== 64'h0303 || halted !== 1'b1 || halt_reason !== 2'b10 || gen_count !== 16'd1) begin
         miscompares++;
         $display("FAIL still_halt grid=%h halt=%b reason=%b gen=%0d exp 0303/1/10/1",
                  grid, halted, halt_reason, gen_count);
      end
      do_start(); do_step(); do_pause(); cyc(6);
      vectors++;
      if (halted !== 1'b1 || running !== 1'b0 || gen_count !== 16'd1 || gen_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL still_hold halt=%b run=%b gen=%0d pulse=%b exp 1/0/1/0",
                  halted, running, gen_count, gen_pulse);
      end
      $display("test_still_life done");
   endtask

   task automatic test_extinction();
      do_load(64'h1);
      do_step();
      vectors++;
      if (grid !== 64'd0 || halted !== 1'b1 || halt_reason !== 2'b01) begin
         miscompares++;
         $display("FAIL extinct grid=%h halt=%b reason=%b exp 0/1/01", grid, halted, halt_reason);
      end
      do_load(64'h0E00);
      vectors++;
      if (halted !== 1'b0 || halt_reason !== 2'b00 || gen_count !== 16'd0 || grid !== 64'h0E00) begin
         miscompares++;
         $display("FAIL reload halt=%b reason=%b gen=%0d grid=%h exp 0/00/0/0e00",
                  halted, halt_reason, gen_count, grid);
      end
      $display("test_extinction done");
   endtask

   task automatic test_toroid();
      do_load(64'h0100_0000_0000_0101);
      do_step();
      vectors++;
      if (grid !== 64'h0000_0000_0000_0083 || halted !== 1'b0) begin
         miscompares++;
         $display("FAIL toroid grid=%h halt=%b exp 83/0", grid, halted);
      end
      $display("test_toroid done");
   endtask

   task automatic test_run_timing();
      int pulses;
      do_load(64'h0E00);
      do_start();
      vectors++;
      if (running !== 1'b1) begin
         miscompares++;
         $display("FAIL run_enter run=%b exp 1", running);
      end
      // Two full intervals: pulse on the 4th and 8th edge after RUN entry only.
      pulses = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         vectors++;
         if (gen_pulse !== ((i % 4) == 0)) begin
            miscompares++;
            $display("FAIL run_period cycle=%0d pulse=%b exp %b", i, gen_pulse, (i % 4) == 0);
         end
         if (gen_pulse) pulses++;
      end
      vectors++;
      if (grid !== 64'h0E00 || gen_count !== 16'd2 || pulses != 2) begin
         miscompares++;
         $display("FAIL run_two_gens grid=%h gen=%0d pulses=%0d exp 0e00/2/2", grid, gen_count, pulses);
      end
      cyc(2);
      do_pause();
      cyc(3);
      vectors++;
      if (running !== 1'b0 || gen_count !== 16'd2) begin
         miscompares++;
         $display("FAIL pause_hold run=%b gen=%0d exp 0/2", running, gen_count);
      end
      do_start();
      cyc(1);
      vectors++;
      if (gen_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL resume_early pulse=%b exp 0", gen_pulse);
      end
      cyc(1);
      vectors++;
      if (gen_pulse !== 1'b1 || gen_count !== 16'd3 || grid !== 64'h0000_0000_0004_0404) begin
         miscompares++;
         $display("FAIL resume_mid pulse=%b gen=%0d grid=%h exp 1/3/40404", gen_pulse, gen_count, grid);
      end
      cyc(3);
      do_pause();
      vectors++;
      if (gen_pulse !== 1'b1 || running !== 1'b0 || halted !== 1'b0 || gen_count !== 16'd4
          || grid !== 64'h0E00) begin
         miscompares++;
         $display("FAIL pause_terminal pulse=%b run=%b halt=%b gen=%0d grid=%h exp 1/0/0/4/0e00",
                  gen_pulse, running, halted, gen_count, grid);
      end
      $display("test_run_timing done");
   endtask

   task automatic test_priority();
      seed = 64'h0303; load = 1'b1; start = 1'b1; cyc(1); load = 1'b0; start = 1'b0;
      vectors++;
      if (running !== 1'b0 || grid !== 64'h0303 || gen_count !== 16'd0 || halted !== 1'b0) begin
         miscompares++;
         $display("FAIL load_over_start run=%b grid=%h gen=%0d halt=%b exp 0/0303/0/0",
                  running, grid, gen_count, halted);
      end
      pause = 1'b1; start = 1'b1; step = 1'b1; cyc(1);
      pause = 1'b0; start = 1'b0; step = 1'b0;
      vectors++;
      if (running !== 1'b0 || gen_count !== 16'd0 || gen_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL pause_over_start run=%b gen=%0d pulse=%b exp 0/0/0", running, gen_count, gen_pulse);
      end
      start = 1'b1; step = 1'b1; cyc(1); start = 1'b0; step = 1'b0;
      vectors++;
      if (running !== 1'b1 || gen_count !== 16'd0) begin
         miscompares++;
         $display("FAIL start_over_step run=%b gen=%0d exp 1/0", running, gen_count);
      end
      $display("test_priority done");
   endtask

   task automatic test_saturation();
      int budget;
      s_seed = 64'h0E00; s_load = 1'b1; cyc(1); s_load = 1'b0;
      s_start = 1'b1; cyc(1); s_start = 1'b0;
      budget = 0;
      while (!s_halted && budget < 100) begin
         cyc(1);
         budget++;
      end
      vectors++;
      if (budget != 28) begin
         miscompares++;
         $display("FAIL sat_timing cycles=%0d exp 28", budget);
      end
      vectors++;
      if (s_halted !== 1'b1 || s_halt_reason !== 2'b11 || s_gen_count !== 3'd7
          || s_grid !== 64'h0000_0000_0004_0404 || s_gen_pulse !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_halt halt=%b reason=%b gen=%0d grid=%h pulse=%b exp 1/11/7/40404/1",
                  s_halted, s_halt_reason, s_gen_count, s_grid, s_gen_pulse);
      end
      s_start = 1'b1; s_step = 1'b1; cyc(1); s_start = 1'b0; s_step = 1'b0;
      cyc(8);
      vectors++;
      if (s_gen_count !== 3'd7 || s_halted !== 1'b1 || s_running !== 1'b0 || s_gen_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_hold gen=%0d halt=%b run=%b pulse=%b exp 7/1/0/0",
                  s_gen_count, s_halted, s_running, s_gen_pulse);
      end
      $display("test_saturation done");
   endtask

   task automatic test_reset_mid_run();
      do_load(64'h0E00);
      do_start();
      cyc(3);
      reset = 1'b1; cyc(1); reset = 1'b0;
      vectors++;
      if ({grid, gen_count, gen_pulse, running, halted, halt_reason} !== 84'd0) begin
         miscompares++;
         $display("FAIL reset_mid_run grid=%h gen=%0d pulse=%b run=%b halt=%b reason=%b exp all zero",
                  grid, gen_count, gen_pulse, running, halted, halt_reason);
      end
      do_start(); cyc(6);
      vectors++;
      if (running !== 1'b0 || gen_count !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_to_idle run=%b gen=%0d exp 0/0", running, gen_count);
      end
      $display("test_reset_mid_run done");
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; step = 1'b0; seed = '0;
      s_reset = 1'b1; s_load = 1'b0; s_start = 1'b0; s_pause = 1'b0; s_step = 1'b0; s_seed = '0;
      cyc(2);
      s_reset = 1'b0;
      test_reset();
      test_blinker();
      test_still_life();
      test_extinction();
      test_toroid();
      test_run_timing();
      test_priority();
      test_saturation();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/life_gen_scheduler.md
Name: life_gen_scheduler

Overview:
- Owns the 8x8 Game-of-Life grid register and sequences generation updates.
- The seed FSM supplies a 64-bit seed. This block loads it, then advances generations at a programmable rate (run) or one at a time (single-step).
- Halts automatically on extinction, still-life or generation-counter saturation.
- Its outputs drive the display path.

Parameters:
- TICK_DIV, 12_500_000: clock cycles per generation while running (>=2).
- TICK_W, 24: tick counter width; must hold TICK_DIV-1.
- GEN_W, 16: generation counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  pulse; copy seed into grid.
- seed  in  64  initial pattern from the seed FSM.
- start  in  1  pulse; enter or resume run.
- pause  in  1  pulse; stop running.
- step  in  1  pulse; advance one generation while paused.
- grid  out  64  current generation; bit r*8+c = cell (row r, col c); 1 = alive.
- gen_count  out  GEN_W  generations applied since last load, saturating.
- gen_pulse  out  1  high for exactly the cycle in which grid shows a newly applied generation.
- running  out  1  state == RUN.
- halted  out  1  state == HALT.
- halt_reason  out  2  00 none, 01 extinct, 10 stable, 11 counter saturated.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE; grid 0; gen_count 0; tick counter 0; gen_pulse 0; running 0; halted 0; halt_reason 00.
- Next-generation function is combinational, rule B3/S23, on a toroidal 8x8 array:
  - neighbour row = (r±1) mod 8, neighbour col = (c±1) mod 8; 8 neighbours per cell.
  - dead cell with exactly 3 live neighbours -> alive.
  - live cell with 2 or 3 live neighbours -> stays alive; otherwise dies.
- "Apply generation" on a clock edge means all of the following, registered together:
  - grid <= next; gen_count <= gen_count+1; gen_pulse <= 1.
  - If next == 0: state <= HALT, reason 01.
  - Else if next == grid: state <= HALT, reason 10.
  - Else if the new gen_count == all-ones: state <= HALT, reason 11.
  - Priority is 01 > 10 > 11.
- States: IDLE, PAUSE, RUN, HALT.
- Input priority is reset > load > pause > start > step. Only one input is acted on per cycle.
- load, in any state:
  - grid <= seed; gen_count <= 0; tick counter <= 0; halt_reason <= 00; state <= PAUSE.
  - No halt check is made on the loaded seed itself.
- IDLE: start and step are ignored; only load leaves IDLE.
- PAUSE:
  - start -> RUN; the tick counter keeps its value, so a run resumes mid-interval.
  - step -> apply generation on that same edge; remain in PAUSE unless a halt condition fires. Tick counter unchanged.
  - pause -> no effect.
- RUN:
  - Tick counter increments each cycle.
  - On the edge where it equals TICK_DIV-1: counter <= 0 and apply generation.
  - The first generation after entering RUN from counter 0 lands TICK_DIV cycles after the RUN-entry edge.
  - pause -> PAUSE, counter held. If pause coincides with the terminal count, the generation is still applied and the state goes to PAUSE, or to HALT if a halt condition fires.
  - start and step are ignored.
- HALT: grid, gen_count and halt_reason are held; start, step and pause are ignored; only load or reset leave.
- gen_count never wraps. Reaching all-ones forces HALT with reason 11.
- gen_pulse is 0 in every cycle except the one following an apply edge.
- Reset mid-run overrides everything on the same edge.

Test Plan:
- Blinker: load seed=0x0000_0000_0000_0E00, then step -> grid=0x0000_0000_0004_0404, gen_count=1, gen_pulse for 1 cycle. Second step -> grid=0x0E00, gen_count=2, state PAUSE.
- Still life: load 0x0000_0000_0000_0303, then step -> grid unchanged, halted=1, halt_reason=10, gen_count=1. Further start/step are ignored.
- Extinction beats stable: load 0x1, then step -> grid=0, halt_reason=01. Load 0x0E00 afterwards -> halted=0, halt_reason=00, gen_count=0.
- Toroidal wrap: load 0x0100_0000_0000_0101 (col 0, rows 7/0/1), then step -> grid=0x0000_0000_0000_0083.
- Run timing with TICK_DIV=4:
  - load 0x0E00, start -> gen_pulse exactly every 4 cycles, first pulse 4 cycles after RUN entry.
  - pause after 2 cycles, then start -> next pulse 2 cycles later.
  - pause coinciding with terminal count -> generation applied, state PAUSE.
- Priority and saturation:
  - load+start in the same cycle -> PAUSE with seed loaded.
  - GEN_W=3 with the blinker running -> HALT reason 11 at gen_count=7.
  - reset asserted mid-RUN -> next cycle grid=0, state IDLE, all outputs at reset values.
